// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the keypad PIN entry front end.
// The display/PIN packet is six BCD digits with index 0 as the rightmost digit.
package pin_entry_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [NUM_DIGITS-1:0][3:0] bcdPac_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] BCD_DASH  = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hB;

  localparam bcdPac_t BCD_ALL_BLANK = {NUM_DIGITS{BCD_BLANK}};

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    PENDING
  } entry_state_t;

  // Digits at or above the entered count are blank; the rest are shown or dashed.
  function automatic bcdPac_t format_packet(input bcdPac_t digits,
                                            input logic [2:0] count,
                                            input logic mask);
    bcdPac_t pkt;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (3'(i) < count) begin
        pkt[i] = mask ? BCD_DASH : digits[i];
      end else begin
        pkt[i] = BCD_BLANK;
      end
    end
    return pkt;
  endfunction

endpackage

// File: rtl/pin_entry_timeout_timer.sv
// Inactivity timer: counts while run is high and flags expiry once it has
// reached TIMEOUT_CYCLES-1; it saturates there until cleared.
module entry_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Held while saturated so an expiry masked by a key press is retried next cycle.
  assign expired = run && (r_cnt == LAST);

endmodule

// File: rtl/pin_entry.sv
// Keypad PIN entry: collects up to six digits, drives the operational display
// packet with an update strobe, and hands completed PINs over a valid/ack pair.
module pin_entry
  import pin_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int MIN_DIGITS     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_entry,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       mask_digits,
  output bcdPac_t    bcd_packet_operacional,
  output logic       enable_o,
  output logic       pin_valid,
  input  logic       pin_ack,
  output bcdPac_t    pin_value,
  output logic [2:0] pin_len,
  output logic       timeout_o
);

  entry_state_t r_state;
  entry_state_t w_state_next;
  bcdPac_t      r_buf;
  bcdPac_t      w_buf_next;
  bcdPac_t      w_shifted;
  logic [2:0]   r_count;
  logic [2:0]   w_count_next;
  logic         r_mask_q;
  bcdPac_t      r_packet;
  logic         r_enable;
  logic         r_pin_valid;
  logic         w_pin_valid_next;
  bcdPac_t      r_pin_value;
  logic [2:0]   r_pin_len;
  logic         r_timeout;

  logic w_pulse;
  logic w_timeout;
  logic w_capture;
  logic w_timer_clr;
  logic w_timer_run;
  logic w_expired;
  logic w_is_digit;
  logic w_mask_edge;

  assign w_is_digit  = (key_code <= 4'd9);
  assign w_mask_edge = (mask_digits != r_mask_q);

  // New digit enters at the right; everything else moves one place left.
  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_shift
      assign w_shifted[gi] = r_buf[gi-1];
    end
  endgenerate
  assign w_shifted[0] = key_code;

  assign w_timer_run = (r_state == ENTRY) && (r_count != 3'd0);

  entry_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (w_timer_run),
    .clear  (!w_timer_run || w_timer_clr),
    .expired(w_expired)
  );

  always_comb begin
    w_state_next     = r_state;
    w_buf_next       = r_buf;
    w_count_next     = r_count;
    w_pin_valid_next = r_pin_valid;
    w_pulse          = 1'b0;
    w_timeout        = 1'b0;
    w_capture        = 1'b0;
    w_timer_clr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable_entry) begin
          w_state_next = ENTRY;
          w_buf_next   = BCD_ALL_BLANK;
          w_count_next = 3'd0;
          w_pulse      = 1'b1;
        end
      end
      ENTRY: begin
        if (!enable_entry) begin
          w_state_next = IDLE;
          w_buf_next   = BCD_ALL_BLANK;
          w_count_next = 3'd0;
          w_pulse      = 1'b1;
        end else if (key_valid) begin
          // Any key in the expiry cycle suppresses the timeout, even an ignored one.
          if (w_is_digit) begin
            if (r_count < 3'(NUM_DIGITS)) begin
              w_buf_next   = w_shifted;
              w_count_next = r_count + 3'd1;
              w_timer_clr  = 1'b1;
              w_pulse      = 1'b1;
            end
          end else if (key_code == KEY_CLEAR) begin
            w_buf_next   = BCD_ALL_BLANK;
            w_count_next = 3'd0;
            w_timer_clr  = 1'b1;
            w_pulse      = 1'b1;
          end else if ((key_code == KEY_ENTER) && (r_count >= 3'(MIN_DIGITS))) begin
            w_capture        = 1'b1;
            w_pin_valid_next = 1'b1;
            w_buf_next       = BCD_ALL_BLANK;
            w_count_next     = 3'd0;
            w_timer_clr      = 1'b1;
            w_pulse          = 1'b1;
            w_state_next     = PENDING;
          end
        end else if (w_expired) begin
          w_buf_next   = BCD_ALL_BLANK;
          w_count_next = 3'd0;
          w_timer_clr  = 1'b1;
          w_timeout    = 1'b1;
          w_pulse      = 1'b1;
        end
        if (enable_entry && (r_count != 3'd0) && w_mask_edge) begin
          w_pulse = 1'b1;
        end
      end
      PENDING: begin
        if (r_pin_valid && pin_ack) begin
          w_pin_valid_next = 1'b0;
          w_state_next     = enable_entry ? ENTRY : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_buf       <= BCD_ALL_BLANK;
      r_count     <= 3'd0;
      r_mask_q    <= 1'b0;
      r_packet    <= BCD_ALL_BLANK;
      r_enable    <= 1'b0;
      r_pin_valid <= 1'b0;
      r_pin_value <= BCD_ALL_BLANK;
      r_pin_len   <= 3'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_buf       <= w_buf_next;
      r_count     <= w_count_next;
      r_mask_q    <= mask_digits;
      r_enable    <= w_pulse;
      r_pin_valid <= w_pin_valid_next;
      r_timeout   <= w_timeout;
      if (w_pulse) begin
        r_packet <= format_packet(w_buf_next, w_count_next, mask_digits);
      end
      if (w_capture) begin
        r_pin_value <= r_buf;
        r_pin_len   <= r_count;
      end
    end
  end

  assign bcd_packet_operacional = r_packet;
  assign enable_o               = r_enable;
  assign pin_valid              = r_pin_valid;
  assign pin_value              = r_pin_value;
  assign pin_len                = r_pin_len;
  assign timeout_o              = r_timeout;

endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry: a per-cycle vector table plus hand-written
// sequences for asynchronous reset and the inactivity timeout.
module tb_pin_entry;
  import pin_entry_pkg::*;

  localparam int TB_TIMEOUT = 20;

  logic       clk;
  logic       rst;
  logic       enable_entry;
  logic       key_valid;
  logic [3:0] key_code;
  logic       mask_digits;
  bcdPac_t    bcd_packet_operacional;
  logic       enable_o;
  logic       pin_valid;
  logic       pin_ack;
  bcdPac_t    pin_value;
  logic [2:0] pin_len;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  pin_entry #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .MIN_DIGITS    (4)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable_entry          (enable_entry),
    .key_valid             (key_valid),
    .key_code              (key_code),
    .mask_digits           (mask_digits),
    .bcd_packet_operacional(bcd_packet_operacional),
    .enable_o              (enable_o),
    .pin_valid             (pin_valid),
    .pin_ack               (pin_ack),
    .pin_value             (pin_value),
    .pin_len               (pin_len),
    .timeout_o             (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        kv;
    logic [3:0]  kc;
    logic        mask;
    logic        ack;
    logic [23:0] pkt;
    logic        eno;
    logic        pv;
    logic [23:0] pval;
    logic [2:0]  plen;
  } vec_t;

  vec_t vecs[29];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic kv, input logic [3:0] kc,
                       input logic mask, input logic ack);
    enable_entry = en;
    key_valid    = kv;
    key_code     = kc;
    mask_digits  = mask;
    pin_ack      = ack;
  endtask

  initial begin
    //            en kv kc    mk ak packet       eno pv pin_value   len
    vecs[0]  = '{1, 0, 4'h0, 0, 0, 24'hBBBBBB, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[1]  = '{1, 1, 4'h1, 0, 0, 24'hBBBBB1, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[2]  = '{1, 1, 4'h2, 0, 0, 24'hBBBB12, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[3]  = '{1, 1, 4'h3, 0, 0, 24'hBBB123, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[4]  = '{1, 1, 4'h4, 0, 0, 24'hBB1234, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[5]  = '{1, 1, 4'h5, 0, 0, 24'hB12345, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[6]  = '{1, 1, 4'h6, 0, 0, 24'h123456, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[7]  = '{1, 1, 4'h7, 0, 0, 24'h123456, 0, 0, 24'hBBBBBB, 3'd0};
    vecs[8]  = '{1, 0, 4'h0, 0, 0, 24'h123456, 0, 0, 24'hBBBBBB, 3'd0};
    vecs[9]  = '{1, 1, 4'hA, 0, 0, 24'hBBBBBB, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[10] = '{1, 1, 4'h9, 0, 0, 24'hBBBBB9, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[11] = '{1, 1, 4'h8, 0, 0, 24'hBBBB98, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[12] = '{1, 1, 4'h7, 0, 0, 24'hBBB987, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[13] = '{1, 1, 4'hB, 0, 0, 24'hBBB987, 0, 0, 24'hBBBBBB, 3'd0};
    vecs[14] = '{1, 1, 4'h6, 0, 0, 24'hBB9876, 1, 0, 24'hBBBBBB, 3'd0};
    vecs[15] = '{1, 1, 4'hB, 0, 0, 24'hBBBBBB, 1, 1, 24'hBB9876, 3'd4};
    vecs[16] = '{1, 1, 4'h5, 0, 0, 24'hBBBBBB, 0, 1, 24'hBB9876, 3'd4};
    vecs[17] = '{1, 0, 4'h0, 0, 1, 24'hBBBBBB, 0, 0, 24'hBB9876, 3'd4};
    vecs[18] = '{1, 1, 4'h3, 0, 0, 24'hBBBBB3, 1, 0, 24'hBB9876, 3'd4};
    vecs[19] = '{1, 1, 4'h4, 0, 0, 24'hBBBB34, 1, 0, 24'hBB9876, 3'd4};
    vecs[20] = '{1, 0, 4'h0, 1, 0, 24'hBBBBAA, 1, 0, 24'hBB9876, 3'd4};
    vecs[21] = '{1, 0, 4'h0, 1, 0, 24'hBBBBAA, 0, 0, 24'hBB9876, 3'd4};
    vecs[22] = '{1, 1, 4'hA, 1, 0, 24'hBBBBBB, 1, 0, 24'hBB9876, 3'd4};
    vecs[23] = '{1, 1, 4'h2, 1, 0, 24'hBBBBBA, 1, 0, 24'hBB9876, 3'd4};
    vecs[24] = '{1, 0, 4'h0, 0, 0, 24'hBBBBB2, 1, 0, 24'hBB9876, 3'd4};
    vecs[25] = '{1, 1, 4'h7, 0, 1, 24'hBBBB27, 1, 0, 24'hBB9876, 3'd4};
    vecs[26] = '{0, 0, 4'h0, 0, 0, 24'hBBBBBB, 1, 0, 24'hBB9876, 3'd4};
    vecs[27] = '{0, 1, 4'h5, 0, 0, 24'hBBBBBB, 0, 0, 24'hBB9876, 3'd4};
    vecs[28] = '{0, 0, 4'h0, 0, 0, 24'hBBBBBB, 0, 0, 24'hBB9876, 3'd4};

    rst = 1'b1;
    drive(0, 0, 4'h0, 0, 0);
    #1;
    check("rst_packet", 32'(bcd_packet_operacional), 32'hBBBBBB);
    check("rst_pin_value", 32'(pin_value), 32'hBBBBBB);
    check("rst_pin_len", 32'(pin_len), 32'd0);
    check("rst_flags", {29'd0, enable_o, pin_valid, timeout_o}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // Asynchronous reset in the middle of an entry.
    drive(1, 0, 4'h0, 0, 0); step();
    drive(1, 1, 4'h1, 0, 0); step();
    drive(1, 1, 4'h2, 0, 0); step();
    $display("reset_seq pre-reset packet=%h enable_o=%0d", bcd_packet_operacional, enable_o);
    check("pre_rst_packet", 32'(bcd_packet_operacional), 32'hBBBB12);
    drive(0, 0, 4'h0, 0, 0);
    rst = 1'b1;
    #1;
    $display("reset_seq async packet=%h enable_o=%0d pin_valid=%0d",
             bcd_packet_operacional, enable_o, pin_valid);
    check("async_rst_packet", 32'(bcd_packet_operacional), 32'hBBBBBB);
    check("async_rst_enable_o", 32'(enable_o), 32'd0);
    check("async_rst_pin_valid", 32'(pin_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle_enable_o", 32'(enable_o), 32'd0);

    // Cycle-by-cycle vectors.
    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].en, vecs[i].kv, vecs[i].kc, vecs[i].mask, vecs[i].ack);
      step();
      $display("vec %0d en=%0d kv=%0d kc=%h mask=%0d ack=%0d -> packet=%h enable_o=%0d pin_valid=%0d pin_value=%h pin_len=%0d timeout_o=%0d",
               i, vecs[i].en, vecs[i].kv, vecs[i].kc, vecs[i].mask, vecs[i].ack,
               bcd_packet_operacional, enable_o, pin_valid, pin_value, pin_len, timeout_o);
      check($sformatf("vec%0d_packet", i), 32'(bcd_packet_operacional), 32'(vecs[i].pkt));
      check($sformatf("vec%0d_enable_o", i), 32'(enable_o), 32'(vecs[i].eno));
      check($sformatf("vec%0d_pin_valid", i), 32'(pin_valid), 32'(vecs[i].pv));
      check($sformatf("vec%0d_pin_value", i), 32'(pin_value), 32'(vecs[i].pval));
      check($sformatf("vec%0d_pin_len", i), 32'(pin_len), 32'(vecs[i].plen));
      check($sformatf("vec%0d_timeout_o", i), 32'(timeout_o), 32'd0);
    end

    // Inactivity timeout after a single digit.
    drive(1, 0, 4'h0, 0, 0); step();
    check("to_enter_enable_o", 32'(enable_o), 32'd1);
    drive(1, 1, 4'h5, 0, 0); step();
    check("to_key_packet", 32'(bcd_packet_operacional), 32'hBBBBB5);
    drive(1, 0, 4'h0, 0, 0);
    for (int i = 1; i < TB_TIMEOUT; i++) begin
      step();
      check($sformatf("to_idle%0d_flags", i), {30'd0, timeout_o, enable_o}, 32'd0);
    end
    step();
    $display("timeout expiry packet=%h enable_o=%0d timeout_o=%0d",
             bcd_packet_operacional, enable_o, timeout_o);
    check("to_expiry_timeout_o", 32'(timeout_o), 32'd1);
    check("to_expiry_enable_o", 32'(enable_o), 32'd1);
    check("to_expiry_packet", 32'(bcd_packet_operacional), 32'hBBBBBB);
    step();
    check("to_after_flags", {30'd0, timeout_o, enable_o}, 32'd0);

    // A key in the expiry cycle wins over the timeout.
    drive(1, 1, 4'h5, 0, 0); step();
    drive(1, 0, 4'h0, 0, 0);
    for (int i = 1; i < TB_TIMEOUT; i++) step();
    drive(1, 1, 4'h6, 0, 0); step();
    $display("timeout race packet=%h enable_o=%0d timeout_o=%0d",
             bcd_packet_operacional, enable_o, timeout_o);
    check("race_timeout_o", 32'(timeout_o), 32'd0);
    check("race_packet", 32'(bcd_packet_operacional), 32'hBBBB56);
    check("race_enable_o", 32'(enable_o), 32'd1);
    drive(1, 0, 4'h0, 0, 0);
    for (int i = 1; i < TB_TIMEOUT; i++) begin
      step();
      check($sformatf("race_idle%0d_timeout_o", i), 32'(timeout_o), 32'd0);
    end
    step();
    check("race_late_timeout_o", 32'(timeout_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_entry.md
Name: pin_entry

Overview:
- Keypad-to-display front end of the lock's operational path.
- Collects up to 6 decimal digits from the keypad decoder and maintains the operational display packet. It pulses enable_o so the display stage latches each update.
- On '#' it hands the completed PIN to the lock controller through a valid/ack handshake.
- Clears the entry after an inactivity timeout.

Parameters:
- TIMEOUT_CYCLES, 5000: idle clk cycles with a non-empty entry before auto-clear; legal values are ≥2.
- MIN_DIGITS, 4: minimum digit count accepted by '#'; legal range is 1..6.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable_entry  in  1  controller permits PIN entry
- key_valid  in  1  one-cycle strobe: key_code is valid
- key_code  in  4  0-9 digit, 4'hA '*' (clear), 4'hB '#' (enter), others ignored
- mask_digits  in  1  1 = show entered digits as dash (4'hA)
- bcd_packet_operacional  out  bcdPac_t  display packet (BCD0 = rightmost)
- enable_o  out  1  one-cycle pulse, packet updated
- pin_valid  out  1  PIN available; held until acknowledged
- pin_ack  in  1  controller consumed PIN
- pin_value  out  bcdPac_t  entered digits, BCD0 = last digit, unused = 4'hB
- pin_len  out  3  number of digits in pin_value (MIN_DIGITS..6)
- timeout_o  out  1  one-cycle pulse on inactivity clear

Behaviour:
- Reset (async, immediate):
  - digit buffer all 4'hB; count=0; timer=0; state IDLE.
  - bcd_packet_operacional all 4'hB; pin_value all 4'hB; pin_len=0.
  - enable_o=0; pin_valid=0; timeout_o=0.
- All outputs are registered. A key sampled at edge N is reflected in the packet and enable_o asserted for the cycle after edge N. This gives 1-cycle latency.
- States:
  - IDLE: keys ignored. enable_entry=1 → ENTRY, buffer cleared, enable_o pulse.
  - ENTRY:
    - Digit with count<6: shift buffer left (BCD5←BCD4…BCD1←BCD0), BCD0←digit, count+1, timer=0, enable_o pulse.
    - Digit with count==6: ignored; no pulse, timer not reset.
    - '*': buffer all 4'hB, count=0, timer=0, enable_o pulse.
    - '#' with count≥MIN_DIGITS: pin_value←buffer, pin_len←count, pin_valid=1. Then buffer cleared, count=0, enable_o pulse, → PENDING.
    - '#' with count<MIN_DIGITS: ignored entirely.
    - enable_entry=0: → IDLE, buffer cleared, enable_o pulse.
  - PENDING: all keys ignored; timer halted. When pin_valid&&pin_ack: pin_valid=0 next cycle, then → ENTRY if enable_entry=1, else IDLE. pin_value/pin_len hold until the next capture.
- Timer:
  - Counts only in ENTRY with count>0.
  - At TIMEOUT_CYCLES-1 with no key_valid: buffer cleared, count=0, timer=0, timeout_o pulse, enable_o pulse in the same cycle.
  - key_valid in the expiry cycle wins; no timeout occurs.
- Packet formation:
  - Positions ≥count are always 4'hB.
  - Positions <count are the digit, or 4'hA when mask_digits=1.
  - A mask_digits change (edge-detected, registered) while in ENTRY with count>0 regenerates the packet with an enable_o pulse.
- enable_o is never asserted two consecutive cycles except on back-to-back events; each event yields exactly one pulse.
- pin_ack without pin_valid: ignored.

Decomposition:
- Shared Tipos package: existing bcdPac_t, plus constants:
  - KEY_CLEAR=4'hA, KEY_ENTER=4'hB.
  - BCD_DASH=4'hA, BCD_BLANK=4'hB.
  - enum entry_state_t {IDLE, ENTRY, PENDING}.
- One sub-module, entry_timeout_timer:
  - Inputs: clk, rst, run, clear.
  - Output: expired pulse.
  - Parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset mid-entry after digits 1,2: rst high → packet all 4'hB, count 0, pin_valid 0 immediately, no enable_o.
- Keys 1,2,3,4,5,6,7: the 7th key is ignored. Final packet is BCD5..BCD0 = 1,2,3,4,5,6. Exactly 7 enable_o pulses total, counting the IDLE→ENTRY pulse.
- Keys 9,8,7,'#' → pin_valid=1, pin_len=3 is NOT produced: '#' is ignored (MIN_DIGITS=4). Then add 6 and '#': pin_valid=1, pin_value BCD3..BCD0 = 9,8,7,6, BCD5/BCD4 = 4'hB, pin_len=4, display blank. Digits during PENDING have no effect. pin_ack → pin_valid=0 next cycle.
- Key 5, then idle TIMEOUT_CYCLES-1 cycles → timeout_o and enable_o pulse, packet all 4'hB. Separately, a key arriving in the expiry cycle → no timeout_o.
- Keys 3,4 with mask_digits=0, then mask_digits raised → enable_o pulse, packet BCD1,BCD0 = 4'hA, others 4'hB. Then '*' → all 4'hB.
- enable_entry dropped in ENTRY with 2 digits → IDLE, packet cleared with one enable_o pulse. Keys in IDLE produce no pulse.
